hi14a_tag_tx: RTL and testbench

HI14A_TAG_TX -- requirements
Module: hi14a_tag_tx

---
 rtl/hi14a_tag_tx.sv | 139 +++++++++++++
 tb/tb_hi14a_tag_tx.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hi14a_tag_tx.sv
// hi14a_tag_tx: ISO14443A tag response transmitter with FDT timing, byte buffer and Manchester/fc-16 load modulation
module hi14a_tag_tx #(
  parameter int FDT_CYCLES = 1172
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic       tx_start,
  input  logic       fdt_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       mod_sig,
  output logic       busy,
  output logic       done,
  output logic       underrun
);
  typedef enum logic [2:0] {IDLE, ARMED, WAIT_FDT, SOF, DATA, PARITY, EOF} state_t;
  localparam logic [11:0] FDT_END = 12'(FDT_CYCLES - 1);
  localparam logic [11:0] FDT_RETRY = 12'(FDT_CYCLES - 128);
  state_t state_q, state_d;
  logic [11:0] fdt_q, fdt_d;
  logic [6:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, buf_q, buf_d;
  logic buf_v_q, buf_v_d, buf_last_q, buf_last_d, cur_last_q, cur_last_d;
  logic par_q, par_d, last_seen_q, last_seen_d;
  logic mod_q, mod_d, busy_q, busy_d, done_q, done_d, ur_q, ur_d;
  logic acc, bit_end, load, sym, half;
  assign tx_ready = !buf_v_q && !last_seen_q && state_q inside {ARMED, WAIT_FDT, SOF, DATA, PARITY};
  assign acc = tx_valid && tx_ready;
  assign bit_end = phase_q == 7'd127;
  always_comb begin
    state_d = state_q;
    fdt_d = fdt_q + 12'd1;
    bit_d = bit_q;
    shift_d = shift_q;
    cur_last_d = cur_last_q;
    par_d = par_q;
    load = 1'b0;
    done_d = 1'b0;
    ur_d = 1'b0;
    buf_v_d = buf_v_q | acc;
    buf_d = acc ? tx_data : buf_q;
    buf_last_d = acc ? tx_last : buf_last_q;
    last_seen_d = last_seen_q | (acc & tx_last);
    case (state_q)
      IDLE: if (tx_start) begin
        state_d = fdt_start ? WAIT_FDT : ARMED;
        fdt_d = '0;
      end
      ARMED: if (fdt_start) begin
        state_d = WAIT_FDT;
        fdt_d = '0;
      end
      WAIT_FDT: if (fdt_start) fdt_d = '0;
        else if (fdt_q == FDT_END) begin
          if (buf_v_q) begin
            state_d = SOF;
            load = 1'b1;
          end else fdt_d = FDT_RETRY;
        end
      SOF: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        bit_d = bit_q + 3'd1;
        shift_d = shift_q >> 1;
        if (bit_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (bit_end) begin
        if (cur_last_q) state_d = EOF;
        else if (buf_v_q) begin
          state_d = DATA;
          load = 1'b1;
        end else begin
          state_d = EOF;
          ur_d = 1'b1;
        end
      end
      EOF: if (bit_end) begin
        state_d = IDLE;
        done_d = 1'b1;
        buf_v_d = 1'b0;
        last_seen_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      shift_d = buf_q;
      par_d = ~^buf_q;
      cur_last_d = buf_last_q;
      buf_v_d = 1'b0;
    end
    phase_d = state_q inside {SOF, DATA, PARITY, EOF} ? phase_q + 7'd1 : 7'd0;
    // output is computed from next-cycle values so the registered mod_sig lines up with the state
    sym = state_d == SOF ? 1'b1 : state_d == PARITY ? par_d : shift_d[0];
    half = phase_d[6] ? !sym : sym;
    mod_d = state_d inside {SOF, DATA, PARITY} && half && !phase_d[3];
    busy_d = state_d != IDLE || done_d;
  end
  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state_q <= IDLE;
      fdt_q <= '0;
      phase_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      buf_q <= '0;
      buf_v_q <= 1'b0;
      buf_last_q <= 1'b0;
      cur_last_q <= 1'b0;
      par_q <= 1'b0;
      last_seen_q <= 1'b0;
      mod_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ur_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fdt_q <= fdt_d;
      phase_q <= phase_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      buf_q <= buf_d;
      buf_v_q <= buf_v_d;
      buf_last_q <= buf_last_d;
      cur_last_q <= cur_last_d;
      par_q <= par_d;
      last_seen_q <= last_seen_d;
      mod_q <= mod_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ur_q <= ur_d;
    end
  end
  assign mod_sig = mod_q;
  assign busy = busy_q;
  assign done = done_q;
  assign underrun = ur_q;
endmodule

// File: tb/tb_hi14a_tag_tx.sv
// tb_hi14a_tag_tx: self-checking bench for hi14a_tag_tx frame timing and modulation waveform
module tb_hi14a_tag_tx;
  logic clk = 0, rst = 1, tx_start = 0, fdt_start = 0, tx_valid = 0, tx_last = 0;
  logic [7:0] tx_data = 0;
  logic tx_ready, mod_sig, busy, done, underrun;
  int checks = 0, errors = 0, cyc = 0;
  bit fed_all;
  logic [7:0] fd[$];
  logic fl[$];
  typedef struct {
    int nb;
    logic [7:0] b0, b1;
    logic l0, l1;
    int feed_at;
    bit same;
    int restart;
    int sof_off;
    int exp_ur;
  } vec_t;
  vec_t vecs[6];
  hi14a_tag_tx #(.FDT_CYCLES(1172)) dut (
    .ck_1356meg(clk), .rst(rst), .tx_start(tx_start), .fdt_start(fdt_start),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .mod_sig(mod_sig), .busy(busy), .done(done), .underrun(underrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] man(input logic b);
    logic [127:0] w;
    for (int i = 0; i < 128; i++) w[i] = (((i / 8) % 2) == 0) && ((i < 64) == b);
    return w;
  endfunction
  task automatic feeder(input int start);
    int n;
    logic r;
    while (cyc < start) tick();
    for (int i = 0; i < fd.size(); i++) begin
      tx_valid = 1;
      tx_data = fd[i];
      tx_last = fl[i];
      n = 0;
      do begin
        @(negedge clk);
        r = tx_ready;
        tick();
        n++;
      end while (!r && n < 4000);
      chk($sformatf("feed_accept%0d", i), r, 1'b1);
    end
    tx_valid = 0;
    tx_last = 0;
    fed_all = 1;
  endtask
  task automatic run_frame(input vec_t v, input string nm);
    logic [127:0] exp_q[$];
    logic [127:0] w;
    int e, t, idx = 0, ur_n = 0, done_n = 0, rdy_n = 0, quiet_n = 0;
    logic lastb;
    fd = {};
    fl = {};
    fed_all = 0;
    fd.push_back(v.b0);
    fl.push_back(v.l0);
    if (v.nb > 1) begin
      fd.push_back(v.b1);
      fl.push_back(v.l1);
    end
    lastb = fl[fl.size() - 1];
    exp_q.push_back(man(1'b1));
    for (int k = 0; k < v.nb; k++) begin
      for (int j = 0; j < 8; j++) exp_q.push_back(man(fd[k][j]));
      exp_q.push_back(man(~^fd[k]));
      if (fl[k]) break;
    end
    exp_q.push_back('0);
    tx_start = 1;
    fdt_start = v.same;
    tick();
    tx_start = 0;
    fdt_start = 0;
    e = cyc;
    t = v.same ? e : e + 4;
    fork
      feeder(v.feed_at < 0 ? e : t + v.feed_at);
      begin
        while (cyc < t - 1) tick();
        if (!v.same) begin
          fdt_start = 1;
          tick();
          fdt_start = 0;
        end
        while (cyc < t + v.sof_off) begin
          if (v.restart > 0 && cyc == t + v.restart - 1) fdt_start = 1;
          quiet_n += int'(mod_sig) + int'(!busy);
          tick();
          fdt_start = 0;
        end
        chk({nm, "_pre_sof_quiet"}, quiet_n, 0);
        while (exp_q.size() > 0) begin
          for (int i = 0; i < 128; i++) begin
            w[i] = mod_sig;
            ur_n += int'(underrun);
            done_n += int'(done);
            if (fed_all && lastb) rdy_n += int'(tx_ready);
            tick();
          end
          chk($sformatf("%s_bit%0d", nm, idx), w, exp_q.pop_front());
          idx++;
        end
        chk({nm, "_underrun"}, ur_n, v.exp_ur);
        chk({nm, "_no_early_done"}, done_n, 0);
        if (lastb) chk({nm, "_ready_after_last"}, rdy_n, 0);
        chk({nm, "_done_busy"}, {done, busy}, 2'b11);
        tick();
        chk({nm, "_idle_after_done"}, {done, busy}, 2'b00);
      end
    join
  endtask
  initial begin
    int t, n;
    vecs[0] = '{1, 8'h26, 8'h00, 1'b1, 1'b0, -1, 1'b0, 0, 1172, 0};
    vecs[1] = '{2, 8'h93, 8'h20, 1'b0, 1'b1, -1, 1'b0, 0, 1172, 0};
    vecs[2] = '{1, 8'h26, 8'h00, 1'b1, 1'b0, 1200, 1'b0, 0, 1300, 0};
    vecs[3] = '{1, 8'h55, 8'h00, 1'b0, 1'b0, -1, 1'b0, 0, 1172, 1};
    vecs[4] = '{1, 8'hA5, 8'h00, 1'b1, 1'b0, -1, 1'b0, 500, 1672, 0};
    vecs[5] = '{1, 8'h3C, 8'h00, 1'b1, 1'b0, 5, 1'b1, 0, 1172, 0};
    tick();
    tick();
    chk("reset_outputs", {mod_sig, tx_ready, busy, done, underrun}, 5'b0);
    rst = 0;
    tick();
    fdt_start = 1;
    tick();
    fdt_start = 0;
    tick();
    chk("idle_ignores_fdt", {busy, tx_ready, mod_sig}, 3'b0);
    for (int i = 0; i < 6; i++) run_frame(vecs[i], $sformatf("vec%0d", i));
    tx_start = 1;
    tick();
    tx_start = 0;
    tx_valid = 1;
    tx_data = 8'h26;
    tx_last = 1;
    tick();
    tx_valid = 0;
    tx_last = 0;
    fdt_start = 1;
    tick();
    fdt_start = 0;
    t = cyc;
    while (cyc < t + 1172 + 300) tick();
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_data", {mod_sig, busy}, 2'b00);
    n = 0;
    fdt_start = 1;
    repeat (300) begin
      n += int'(done) + int'(underrun) + int'(busy) + int'(mod_sig);
      tick();
      fdt_start = 0;
    end
    chk("rst_no_done", n, 0);
    run_frame(vecs[0], "post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
